// File: rtl/vmcoffee_multi.sv
// Multi-product coffee vending controller: coins/NFC credit, timed brew, 5-unit change.
// Optional CANCEL input and refund path when VMC_CANCEL_EN is defined.
module vmcoffee_multi #(
    parameter int PRICE       = 2,
    parameter int PRICE_STEP  = 1,
    parameter int N_PROD      = 2,
    parameter int CREDIT_W    = 4,
    parameter int WATER_W     = 5,
    parameter int WATER_MIN   = 2,
    parameter int BREW_CYCLES = 3,
    parameter int SEL_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                C5,
    input  logic                C10,
    input  logic                NFC,
    input  logic                BEANS,
    input  logic [WATER_W-1:0]  WATER,
    input  logic [SEL_W-1:0]    SEL,
    output logic                COFFEE,
    output logic                ERROR,
    output logic                CHANGE5,
    output logic [CREDIT_W-1:0] CREDIT
`ifdef VMC_CANCEL_EN
    ,
    input  logic                CANCEL
`endif
);

    localparam int CMAX  = (1 << CREDIT_W) - 1;
    localparam int PMAX  = PRICE + (N_PROD - 1) * PRICE_STEP;
    localparam int CNT_W = (BREW_CYCLES > 1) ? $clog2(BREW_CYCLES) : 1;

    if (PMAX > CMAX) begin : g_price_chk
        $error("vmcoffee_multi: product price exceeds credit range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_BREW,
        S_CHANGE,
        S_FAULT
    } state_t;

    state_t              r_state, w_next;
    logic [CREDIT_W-1:0] r_credit, w_credit_nx;
    logic [CREDIT_W-1:0] r_price, w_price_nx;
    logic                r_paid, w_paid_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;

    logic r_c5_s, r_c5_d, r_c5_e;
    logic r_c10_s, r_c10_d, r_c10_e;
    logic r_nfc_s, r_nfc_d, r_nfc_e;
    logic r_coffee, r_chg, r_err;

    logic                w_fault;
    logic                w_coin;
    logic [1:0]          w_add;
    logic [CREDIT_W+1:0] w_sum;
    logic [CREDIT_W-1:0] w_sat;
    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W-1:0] w_left;

    assign w_fault = (WATER < WATER_W'(WATER_MIN)) | ~BEANS;
    // C5 weighs 1 and C10 weighs 2, so the edge pair is already the increment
    assign w_add   = {r_c10_e, r_c5_e};
    assign w_coin  = r_c5_e | r_c10_e;
    assign w_sum   = {2'b00, r_credit} + {CREDIT_W'(0), w_add};
    assign w_sat   = (w_sum > (CREDIT_W+2)'(CMAX)) ? CREDIT_W'(CMAX)
                                                   : w_sum[CREDIT_W-1:0];
    assign w_price = CREDIT_W'(PRICE + int'(SEL) * PRICE_STEP);
    assign w_left  = r_paid ? r_credit : (r_credit - r_price);

`ifdef VMC_CANCEL_EN
    logic r_can_s, r_can_d, r_can_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_can_s <= 1'b0;
            r_can_d <= 1'b0;
            r_can_e <= 1'b0;
        end else begin
            r_can_s <= CANCEL;
            r_can_d <= r_can_s;
            r_can_e <= r_can_s & ~r_can_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c5_s  <= 1'b0;
            r_c5_d  <= 1'b0;
            r_c5_e  <= 1'b0;
            r_c10_s <= 1'b0;
            r_c10_d <= 1'b0;
            r_c10_e <= 1'b0;
            r_nfc_s <= 1'b1;
            r_nfc_d <= 1'b1;
            r_nfc_e <= 1'b0;
        end else begin
            r_c5_s  <= C5;
            r_c5_d  <= r_c5_s;
            r_c5_e  <= r_c5_s & ~r_c5_d;
            r_c10_s <= C10;
            r_c10_d <= r_c10_s;
            r_c10_e <= r_c10_s & ~r_c10_d;
            r_nfc_s <= NFC;
            r_nfc_d <= r_nfc_s;
            r_nfc_e <= ~r_nfc_s & r_nfc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_price  <= '0;
            r_paid   <= 1'b0;
            r_cnt    <= '0;
            r_coffee <= 1'b0;
            r_chg    <= 1'b0;
            r_err    <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_credit <= w_credit_nx;
            r_price  <= w_price_nx;
            r_paid   <= w_paid_nx;
            r_cnt    <= w_cnt_nx;
            r_coffee <= (r_state == S_BREW);
            r_chg    <= (r_state == S_CHANGE);
            r_err    <= ~w_fault;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_credit_nx = r_credit;
        w_price_nx  = r_price;
        w_paid_nx   = r_paid;
        w_cnt_nx    = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_fault) begin
                    w_next = S_FAULT;
                end else if (r_nfc_e) begin
                    w_next      = S_BREW;
                    w_credit_nx = w_sat;
                    w_paid_nx   = 1'b1;
                    w_price_nx  = w_price;
                    w_cnt_nx    = '0;
                end else if (w_coin) begin
                    w_next      = S_CREDIT;
                    w_credit_nx = w_sat;
                end
            end
            S_CREDIT: begin
                if (w_fault) begin
                    w_next = (r_credit != '0) ? S_CHANGE : S_FAULT;
                end else begin
                    w_credit_nx = w_sat;
                    if (r_nfc_e || (w_sat >= w_price)) begin
                        w_next     = S_BREW;
                        w_paid_nx  = r_nfc_e;
                        w_price_nx = w_price;
                        w_cnt_nx   = '0;
`ifdef VMC_CANCEL_EN
                    end else if (r_can_e) begin
                        w_next = (w_sat != '0) ? S_CHANGE : S_IDLE;
`endif
                    end
                end
            end
            S_BREW: begin
                // a fault during the brew is only acted on once the drink is done
                if (r_cnt == CNT_W'(BREW_CYCLES - 1)) begin
                    w_credit_nx = w_left;
                    w_paid_nx   = 1'b0;
                    if (w_left != '0)
                        w_next = S_CHANGE;
                    else if (w_fault)
                        w_next = S_FAULT;
                    else
                        w_next = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_CHANGE: begin
                w_credit_nx = (r_credit != '0) ? (r_credit - CREDIT_W'(1)) : '0;
                if (r_credit <= CREDIT_W'(1))
                    w_next = w_fault ? S_FAULT : S_IDLE;
            end
            S_FAULT: begin
                w_credit_nx = '0;
                if (!w_fault)
                    w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign COFFEE  = r_coffee;
    assign ERROR   = r_err;
    assign CHANGE5 = r_chg;
    assign CREDIT  = r_credit;

endmodule

// File: doc/vmcoffee_multi.md
# vmcoffee_multi

Parametrised multi-product coffee vending controller, successor to the single-price coin/NFC machine. It accepts 5- and 10-unit coins and NFC payment, and supports products with different prices. It returns change as 5-unit pulses, gates service on water level and beans, and drives a timed brew output. It sits between the coin/NFC front-end and the brewer/hopper actuators.

## Interface
- PRICE, 2, price of product 0 in 5-unit steps
- PRICE_STEP, 1, extra 5-unit steps per product index (product k costs PRICE + k*PRICE_STEP)
- N_PROD, 2, number of products (SEL width = clog2(N_PROD), min 1)
- CREDIT_W, 4, credit register width in 5-unit steps
- WATER_W, 5, water level sensor width
- WATER_MIN, 2, minimum water level for service
- BREW_CYCLES, 3, cycles COFFEE is held high per drink
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- C5  input  1  5-unit coin present (level; counted on 0->1)
- C10  input  1  10-unit coin present (level; counted on 0->1)
- NFC  input  1  NFC payment, active-low (counted on 1->0)
- BEANS  input  1  1 = beans present
- WATER  input  WATER_W  water level
- SEL  input  clog2(N_PROD)  product select, sampled on entry to BREW
- COFFEE  output  1  brew/dispense active
- ERROR  output  1  active-low fault: 0 = WATER < WATER_MIN or BEANS = 0
- CHANGE5  output  1  one-cycle pulse per 5-unit coin returned
- CREDIT  output  CREDIT_W  current credit in 5-unit steps

## Operation
- Fault = (WATER < WATER_MIN) | ~BEANS; ERROR = ~fault, registered.
- C5, C10 and NFC are registered once; edges are detected against a second register. Flops reset to C5 = 0, C10 = 0 and NFC = 1.
- States: IDLE, CREDIT, BREW, CHANGE, FAULT.
- IDLE: coin edge adds credit and moves to CREDIT. NFC edge loads nfc_paid and moves to BREW. Fault moves to FAULT.
- CREDIT: C5 edge adds 1 and C10 edge adds 2; both in the same cycle add 3. Credit saturates at 2^CREDIT_W-1.
  - credit >= price(SEL) or NFC edge -> BREW.
  - Fault with credit > 0 -> CHANGE (full refund), then FAULT.
- BREW: price latched from SEL. COFFEE = 1 for exactly BREW_CYCLES cycles. Coin and NFC edges are ignored. A fault arising mid-brew does not abort the drink. On exit, credit -= price, or is unchanged if nfc_paid.
- CHANGE: one CHANGE5 pulse per cycle, decrementing credit, until credit = 0.
  - Exit -> FAULT if fault, else IDLE.
- FAULT: coins and NFC ignored; CREDIT = 0. When fault clears -> IDLE.
- Price > 2^CREDIT_W-1 is illegal (synthesis-time assertion).

## Timing
- Reset values: COFFEE 0, ERROR 1, CHANGE5 0, CREDIT 0, state IDLE, nfc_paid 0.
- Coin level high at edge k -> CREDIT updated at edge k+2 (sync + edge register).
- Credit reaching price at edge n -> COFFEE = 1 from edge n+1 for BREW_CYCLES cycles.
- NFC low at edge k -> COFFEE = 1 from edge k+3.
- Fault sensing: sensor change at edge k -> ERROR updated at k+1, and the state reacts on the same edge.
- CHANGE: first CHANGE5 pulse the cycle after BREW ends; pulses are back-to-back.
- Reset mid-operation: all state, credit and pending change are discarded immediately, with no refund.

## Configuration
- VMC_CANCEL_EN defined:
  - Adds input CANCEL (1 bit, counted on 0->1, same sync path as the coins).
  - In CREDIT, a CANCEL edge -> CHANGE, refunding the full credit; it is ignored in other states.
  - Same-cycle CANCEL and credit reaching price: BREW wins.
- VMC_CANCEL_EN undefined: no CANCEL port; credit is held in CREDIT until price is reached or a fault occurs.

## Test plan
- Reset: rst = 1 pulse -> COFFEE 0, ERROR 1, CREDIT 0, state IDLE.
- Defaults, SEL = 0, two C5 coins -> COFFEE high 3 cycles, CREDIT 0, no CHANGE5.
- SEL = 1 (price 3), C5 then C10 -> CREDIT 1 then 3, brew, zero change. With SEL = 0 the same coins -> brew, then one CHANGE5 pulse.
- NFC 1->0 with CREDIT = 1 -> COFFEE at k+3 for 3 cycles, then one CHANGE5 refund, IDLE.
- WATER = 1 with CREDIT = 1 -> ERROR 0, one CHANGE5 refund, FAULT. Coins ignored there. WATER = 30 -> ERROR 1, IDLE.
- BEANS -> 0 during BREW -> COFFEE completes 3 cycles, then FAULT. With VMC_CANCEL_EN, a CANCEL edge at CREDIT = 2 -> two CHANGE5 pulses.
